// File: rtl/noc_mux_arb.sv
// noc_mux_arb: N:1 router output mux; forwards whole packets from one port, RR or static select.
// Latency: 1 cycle, input handshake -> odata/ovalid/ovch (registered output).
// Backpressure: output register loads when empty or oready=1; only the granted port sees iready.
// Optional: define NOC_MUX_TOGGLE_CNT_EN to add the toggle_cnt output (odata bit-flip counter).
module noc_mux_arb #(
  parameter int NPORT = 2,
  parameter int DATAW = 64,
  parameter int TYPEW = 3,
  parameter int VCHW  = 2,
  parameter int MODE  = 1,
  parameter int SELW  = 3
) (
  input  logic                             clk,
  input  logic                             rst_,
  input  logic [NPORT*(TYPEW+DATAW)-1:0]   idata,
  input  logic [NPORT-1:0]                 ivalid,
  input  logic [NPORT*VCHW-1:0]            ivch,
  output logic [NPORT-1:0]                 iready,
  input  logic [SELW-1:0]                  sel,
  output logic [TYPEW+DATAW-1:0]           odata,
  output logic                             ovalid,
  output logic [VCHW-1:0]                  ovch,
  input  logic                             oready,
`ifdef NOC_MUX_TOGGLE_CNT_EN
  output logic [31:0]                      toggle_cnt,
`endif
  output logic                             err
);

  localparam int FLITW = TYPEW + DATAW;
  localparam int PW    = (NPORT > 1) ? $clog2(NPORT) : 1;

  localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [FLITW-1:0]  odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic [VCHW-1:0]   ovch_q, ovch_d;
  logic              err_q, err_d;

  logic [FLITW-1:0]  flit  [NPORT];
  logic [TYPEW-1:0]  ftype [NPORT];
  logic [VCHW-1:0]   fvch  [NPORT];
  logic [NPORT-1:0]  cand;
  logic [NPORT-1:0]  bad_idle;

  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cur;
  logic [FLITW-1:0]  cur_flit;
  logic [TYPEW-1:0]  cur_type;
  logic [VCHW-1:0]   cur_vch;
  logic              cur_vld;
  logic              space;
  logic              go;

  // Output register can take a new flit when it is empty or being drained this cycle.
  assign space = ~ovalid_q | oready;

  // Split the input buses per port; find HEAD candidates and flits that are illegal outside a packet.
  always_comb begin
    cand     = '0;
    bad_idle = '0;
    for (int i = 0; i < NPORT; i++) begin
      flit[i]     = idata[i*FLITW +: FLITW];
      ftype[i]    = flit[i][FLITW-1 -: TYPEW];
      fvch[i]     = ivch[i*VCHW +: VCHW];
      cand[i]     = ivalid[i] && (ftype[i] == T_HEAD);
      bad_idle[i] = ivalid[i] && (ftype[i] != T_HEAD) && (ftype[i] != T_NONE);
    end
  end

  // Pick the IDLE winner: first candidate at/after rr_ptr (RR), or the sel port if it is a candidate.
  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    if (MODE == 1) begin
      // Walk from the far end back so the candidate nearest rr_ptr is the last (winning) assignment.
      for (int k = NPORT-1; k >= 0; k--) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NPORT) j = j - NPORT;
        for (int i = 0; i < NPORT; i++) begin
          if ((i == j) && cand[i]) begin
            win_vld = 1'b1;
            win_idx = PW'(i);
          end
        end
      end
    end else begin
      // Out-of-range sel matches no port, so no grant is given.
      for (int i = 0; i < NPORT; i++) begin
        if ((int'(sel) == i) && cand[i]) begin
          win_vld = 1'b1;
          win_idx = PW'(i);
        end
      end
    end
  end

  // Route the port being served: the locked grant in LOCK, the arbitration winner in IDLE.
  always_comb begin
    cur      = (state_q == LOCK) ? grant_q : win_idx;
    cur_flit = '0;
    cur_type = '0;
    cur_vch  = '0;
    cur_vld  = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (PW'(i) == cur) begin
        cur_flit = flit[i];
        cur_type = ftype[i];
        cur_vch  = fvch[i];
        cur_vld  = ivalid[i];
      end
    end
  end

  // State register plus the registered output stage.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
      err_q    <= err_d;
    end
  end

  // Next state: lock on an accepted HEAD, release on an accepted TAIL and advance the RR pointer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = LOCK;
          grant_d = win_idx;
        end
      end
      LOCK: begin
        if (go && (cur_type == T_TAIL)) begin
          state_d = IDLE;
          if (MODE == 1) begin
            rr_ptr_d = (int'(grant_q) == NPORT-1) ? '0 : grant_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake, error detection and output-register loads. NONE flits are never taken; iready is
  // held low while reset is asserted so no upstream handshake can complete during reset.
  always_comb begin
    go       = 1'b0;
    err_d    = 1'b0;
    iready   = '0;
    odata_d  = odata_q;
    ovch_d   = ovch_q;
    ovalid_d = ovalid_q;
    if (state_q == LOCK) begin
      go    = cur_vld & space & (cur_type != T_NONE);
      err_d = go & (cur_type == T_HEAD);
    end else begin
      go    = win_vld & space;
      err_d = |bad_idle;
    end
    for (int i = 0; i < NPORT; i++) begin
      iready[i] = rst_ & space & (PW'(i) == cur) &
                  ((state_q == LOCK) ? (cur_type != T_NONE) : win_vld);
    end
    if (go) begin
      odata_d  = cur_flit;
      ovch_d   = cur_vch;
      ovalid_d = 1'b1;
    end else if (space) begin
      ovalid_d = 1'b0;
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;
  assign err    = err_q;

`ifdef NOC_MUX_TOGGLE_CNT_EN
  logic [31:0]      tcnt_q, tcnt_d;
  logic [32:0]      tsum;
  logic [FLITW-1:0] tdiff;

  // Add the number of odata bits that flip on each load; clamp at all ones.
  always_comb begin
    tdiff = odata_d ^ odata_q;
    tsum  = {1'b0, tcnt_q};
    if (go) begin
      for (int b = 0; b < FLITW; b++) begin
        tsum = tsum + 33'(tdiff[b]);
      end
    end
    tcnt_d = tsum[32] ? 32'hFFFF_FFFF : tsum[31:0];
  end

  // Toggle counter register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) tcnt_q <= '0;
    else       tcnt_q <= tcnt_d;
  end

  assign toggle_cnt = tcnt_q;
`endif

endmodule

// File: tb/tb_noc_mux_arb.sv
// Bench for noc_mux_arb: a round-robin and a static-select instance share one set of inputs.
// Table rows drive the static instance; hand-written sequences cover RR packet order,
// back-pressure, mid-packet reset and (when enabled) the toggle counter.
module tb_noc_mux_arb;

  localparam logic [2:0] TN = 3'd0;
  localparam logic [2:0] TH = 3'd1;
  localparam logic [2:0] TD = 3'd2;
  localparam logic [2:0] TT = 3'd3;

  logic         clk = 1'b0;
  logic         rst_;
  logic [125:0] idata;
  logic [1:0]   ivalid;
  logic [3:0]   ivch;
  logic [2:0]   sel;
  logic         oready;

  logic [1:0]   rr_iready, st_iready;
  logic [62:0]  rr_odata, st_odata;
  logic         rr_ovalid, st_ovalid;
  logic [1:0]   rr_ovch, st_ovch;
  logic         rr_err, st_err;
`ifdef NOC_MUX_TOGGLE_CNT_EN
  logic [31:0]  rr_tcnt, st_tcnt;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  noc_mux_arb #(.NPORT(2), .DATAW(60), .TYPEW(3), .VCHW(2), .MODE(1), .SELW(3)) dut_rr (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(rr_iready),
    .sel(sel), .odata(rr_odata), .ovalid(rr_ovalid), .ovch(rr_ovch), .oready(oready),
`ifdef NOC_MUX_TOGGLE_CNT_EN
    .toggle_cnt(rr_tcnt),
`endif
    .err(rr_err));

  noc_mux_arb #(.NPORT(2), .DATAW(60), .TYPEW(3), .VCHW(2), .MODE(0), .SELW(3)) dut_st (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(st_iready),
    .sel(sel), .odata(st_odata), .ovalid(st_ovalid), .ovch(st_ovch), .oready(oready),
`ifdef NOC_MUX_TOGGLE_CNT_EN
    .toggle_cnt(st_tcnt),
`endif
    .err(st_err));

  typedef struct packed {
    logic [1:0] iv;
    logic [2:0] t0;
    logic [2:0] t1;
    logic [7:0] p0;
    logic [7:0] p1;
    logic [2:0] sel;
    logic       ordy;
    logic [1:0] e_irdy;
    logic       e_ov;
    logic [2:0] e_t;
    logic [7:0] e_p;
    logic [1:0] e_vch;
    logic       e_err;
  } vec_t;

  localparam int NROW = 16;
  vec_t vt [NROW];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic set_flit(input int p, input logic v, input logic [62:0] f);
    idata[p*63 +: 63] = f;
    ivalid[p] = v;
  endtask

  function automatic logic [62:0] flit_of(input int p, input int k, input int last);
    logic [2:0] t;
    t = (k == 0) ? TH : ((k == last) ? TT : TD);
    return {t, 60'(p*256 + k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ivalid = '0;
    idata  = '0;
    oready = 1'b1;
    sel    = '0;
    rst_   = 1'b0;
    tick();
    rst_   = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ptr0, ptr1, outcnt;
    logic [1:0]  tk;
    logic [62:0] held;

    //            iv     t0  t1  p0     p1     sel   ordy  irdy   ov    t   p      vch   err
    vt[0]  = '{2'b11, TH, TH, 8'h10, 8'h20, 3'd1, 1'b1, 2'b10, 1'b1, TH, 8'h20, 2'd2, 1'b0};
    vt[1]  = '{2'b11, TH, TD, 8'h10, 8'h21, 3'd0, 1'b1, 2'b10, 1'b1, TD, 8'h21, 2'd2, 1'b0};
    vt[2]  = '{2'b01, TH, TD, 8'h10, 8'h21, 3'd0, 1'b1, 2'b10, 1'b0, TD, 8'h21, 2'd2, 1'b0};
    vt[3]  = '{2'b11, TH, TH, 8'h10, 8'h22, 3'd0, 1'b1, 2'b10, 1'b1, TH, 8'h22, 2'd2, 1'b1};
    vt[4]  = '{2'b11, TH, TT, 8'h10, 8'h23, 3'd0, 1'b1, 2'b10, 1'b1, TT, 8'h23, 2'd2, 1'b0};
    vt[5]  = '{2'b11, TH, TD, 8'h10, 8'h30, 3'd0, 1'b1, 2'b01, 1'b1, TH, 8'h10, 2'd1, 1'b1};
    vt[6]  = '{2'b01, TT, TN, 8'h11, 8'h00, 3'd1, 1'b1, 2'b01, 1'b1, TT, 8'h11, 2'd1, 1'b0};
    vt[7]  = '{2'b11, TH, TH, 8'h12, 8'h24, 3'd7, 1'b1, 2'b00, 1'b0, TT, 8'h11, 2'd1, 1'b0};
    vt[8]  = '{2'b01, TD, TN, 8'h40, 8'h00, 3'd0, 1'b1, 2'b00, 1'b0, TT, 8'h11, 2'd1, 1'b1};
    vt[9]  = '{2'b01, TN, TN, 8'h41, 8'h00, 3'd0, 1'b1, 2'b00, 1'b0, TT, 8'h11, 2'd1, 1'b0};
    vt[10] = '{2'b01, TH, TN, 8'h50, 8'h00, 3'd0, 1'b0, 2'b01, 1'b1, TH, 8'h50, 2'd1, 1'b0};
    vt[11] = '{2'b01, TD, TN, 8'h51, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1, TH, 8'h50, 2'd1, 1'b0};
    vt[12] = '{2'b01, TD, TN, 8'h51, 8'h00, 3'd0, 1'b1, 2'b01, 1'b1, TD, 8'h51, 2'd1, 1'b0};
    vt[13] = '{2'b11, TT, TH, 8'h52, 8'h25, 3'd1, 1'b1, 2'b01, 1'b1, TT, 8'h52, 2'd1, 1'b0};
    vt[14] = '{2'b10, TN, TH, 8'h00, 8'h25, 3'd1, 1'b1, 2'b10, 1'b1, TH, 8'h25, 2'd2, 1'b0};
    vt[15] = '{2'b00, TN, TN, 8'h00, 8'h00, 3'd1, 1'b1, 2'b00, 1'b0, TH, 8'h25, 2'd2, 1'b0};

    // Reset state, with an otherwise valid HEAD presented.
    rst_ = 1'b0; idata = '0; ivalid = '0; ivch = {2'd2, 2'd1}; sel = '0; oready = 1'b1;
    set_flit(0, 1'b1, flit_of(0, 0, 1));
    #2;
    chk("rst_odata",  64'(rr_odata),  64'd0);
    chk("rst_ovalid", 64'(rr_ovalid), 64'd0);
    chk("rst_ovch",   64'(rr_ovch),   64'd0);
    chk("rst_iready", 64'(rr_iready), 64'd0);
    chk("rst_err",    64'(rr_err),    64'd0);
    chk("rst_st_iready", 64'(st_iready), 64'd0);
    do_reset();

    // Static-select table.
    for (int r = 0; r < NROW; r++) begin
      set_flit(0, vt[r].iv[0], {vt[r].t0, 52'h0, vt[r].p0});
      set_flit(1, vt[r].iv[1], {vt[r].t1, 52'h0, vt[r].p1});
      sel    = vt[r].sel;
      oready = vt[r].ordy;
      #1;
      chk($sformatf("r%0d_iready", r), 64'(st_iready), 64'(vt[r].e_irdy));
      tick();
      chk($sformatf("r%0d_ovalid", r), 64'(st_ovalid), 64'(vt[r].e_ov));
      chk($sformatf("r%0d_odata", r),  64'(st_odata),  64'({vt[r].e_t, 52'h0, vt[r].e_p}));
      chk($sformatf("r%0d_ovch", r),   64'(st_ovch),   64'(vt[r].e_vch));
      chk($sformatf("r%0d_err", r),    64'(st_err),    64'(vt[r].e_err));
    end

    // Round-robin: two 22-flit packets from cycle 0; port0 first, then port1, back to back.
    do_reset();
    ptr0 = 0; ptr1 = 0;
    for (int c = 0; c < 48; c++) begin
      set_flit(0, ptr0 < 22, flit_of(0, ptr0, 21));
      set_flit(1, ptr1 < 22, flit_of(1, ptr1, 21));
      #1;
      tk = ivalid & rr_iready;
      tick();
      if (tk[0]) ptr0++;
      if (tk[1]) ptr1++;
      if (c < 44) begin
        chk($sformatf("rr_c%0d_ovalid", c), 64'(rr_ovalid), 64'd1);
        chk($sformatf("rr_c%0d_odata", c),  64'(rr_odata),
            64'(flit_of((c < 22) ? 0 : 1, (c < 22) ? c : c - 22, 21)));
        chk($sformatf("rr_c%0d_ovch", c),   64'(rr_ovch), 64'((c < 22) ? 1 : 2));
      end else begin
        chk($sformatf("rr_c%0d_ovalid", c), 64'(rr_ovalid), 64'd0);
      end
      chk($sformatf("rr_c%0d_err", c), 64'(rr_err), 64'd0);
    end

    // Pointer wrapped to port0; after a port0 packet it moves on to port1.
    set_flit(0, 1'b1, flit_of(0, 0, 1));
    set_flit(1, 1'b1, flit_of(1, 0, 1));
    #1;
    chk("rr_wrap_grant0", 64'(rr_iready), 64'd1);
    tick();
    set_flit(0, 1'b1, flit_of(0, 1, 1));
    #1;
    chk("rr_lock_port0", 64'(rr_iready), 64'd1);
    tick();
    set_flit(0, 1'b1, flit_of(0, 0, 1));
    #1;
    chk("rr_next_grant1", 64'(rr_iready), 64'd2);

    // Back-pressure: oready low for 5 cycles while locked.
    do_reset();
    ptr0 = 0; outcnt = 0; held = '0;
    for (int c = 0; c < 30; c++) begin
      set_flit(0, ptr0 < 8, flit_of(0, ptr0, 7));
      set_flit(1, 1'b0, '0);
      oready = (c >= 2 && c < 7) ? 1'b0 : 1'b1;
      #1;
      if (c >= 2 && c < 7) begin
        chk($sformatf("bp_c%0d_iready", c), 64'(rr_iready), 64'd0);
        if (c == 2) held = rr_odata;
        else chk($sformatf("bp_c%0d_hold", c), 64'(rr_odata), 64'(held));
      end
      if (rr_ovalid && oready) begin
        chk($sformatf("bp_out%0d", outcnt), 64'(rr_odata), 64'(flit_of(0, outcnt, 7)));
        outcnt++;
      end
      tk = ivalid & rr_iready;
      tick();
      if (tk[0]) ptr0++;
    end
    chk("bp_out_count", 64'(outcnt), 64'd8);
    chk("bp_in_count",  64'(ptr0),   64'd8);

    // Reset in the middle of a packet.
    do_reset();
    set_flit(0, 1'b1, flit_of(0, 0, 3));
    tick();
    set_flit(0, 1'b1, flit_of(0, 1, 3));
    tick();
    rst_ = 1'b0;
    #1;
    chk("mid_rst_odata",  64'(rr_odata),  64'd0);
    chk("mid_rst_ovalid", 64'(rr_ovalid), 64'd0);
    chk("mid_rst_ovch",   64'(rr_ovch),   64'd0);
    chk("mid_rst_iready", 64'(rr_iready), 64'd0);
    chk("mid_rst_err",    64'(rr_err),    64'd0);
    ivalid = '0;
    #1;
    rst_ = 1'b1;
    tick();
    chk("post_rst_ovalid", 64'(rr_ovalid), 64'd0);
    chk("post_rst_err",    64'(rr_err),    64'd0);

`ifdef NOC_MUX_TOGGLE_CNT_EN
    // Toggle counter: 0 -> all ones -> 0 payload, type bits included.
    do_reset();
    chk("tc_reset", 64'(rr_tcnt), 64'd0);
    set_flit(0, 1'b1, {TH, 60'h0});
    tick();
    chk("tc_load1", 64'(rr_tcnt), 64'd1);
    set_flit(0, 1'b1, {TD, {60{1'b1}}});
    tick();
    chk("tc_load2", 64'(rr_tcnt), 64'd63);
    set_flit(0, 1'b1, {TT, 60'h0});
    tick();
    chk("tc_load3", 64'(rr_tcnt), 64'd124);
    set_flit(0, 1'b0, '0);
    tick();
    chk("tc_noload", 64'(rr_tcnt), 64'd124);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
